// File: rtl/lifo_fifo_if.sv
// Request/response bundle for lifo_fifo; master drives requests, slave returns data and status.
// Error-flag signals exist only when LIFO_FIFO_ERR_FLAGS_EN is defined.
interface lifo_fifo_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
);
  logic              mode_i;
  logic              wrreq_i;
  logic [DWIDTH-1:0] data_i;
  logic              rdreq_i;
  logic [DWIDTH-1:0] q_o;
  logic              mode_o;
  logic              empty_o;
  logic              almost_empty_o;
  logic              full_o;
  logic              almost_full_o;
  logic [AWIDTH:0]   usedw_o;
`ifdef LIFO_FIFO_ERR_FLAGS_EN
  logic              clr_err_i;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output mode_i, wrreq_i, data_i, rdreq_i, clr_err_i,
    input  q_o, mode_o, empty_o, almost_empty_o, full_o, almost_full_o, usedw_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  mode_i, wrreq_i, data_i, rdreq_i, clr_err_i,
    output q_o, mode_o, empty_o, almost_empty_o, full_o, almost_full_o, usedw_o,
           overflow_o, underflow_o
  );
`else
  modport master (
    output mode_i, wrreq_i, data_i, rdreq_i,
    input  q_o, mode_o, empty_o, almost_empty_o, full_o, almost_full_o, usedw_o
  );

  modport slave (
    input  mode_i, wrreq_i, data_i, rdreq_i,
    output q_o, mode_o, empty_o, almost_empty_o, full_o, almost_full_o, usedw_o
  );
`endif
endinterface

// File: rtl/lifo_fifo.sv
// Switchable LIFO/FIFO buffer, q_o one cycle after an accepted read; full/empty reject requests (rd+wr on full both accepted).
// Optional sticky overflow/underflow flags with clr_err_i when LIFO_FIFO_ERR_FLAGS_EN is defined.
module lifo_fifo #(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2
) (
  input logic       clk_i,
  input logic       srst_i,
  lifo_fifo_if.slave bus
);
  localparam int              DEPTH   = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(ALMOST_EMPTY);
  localparam logic [AWIDTH:0] ONE_W   = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] ONE_A = AWIDTH'(1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   usedw;
  logic [DWIDTH-1:0] q;
  logic              mode;

  logic              is_empty;
  logic              is_full;
  logic              rd_acc;
  logic              wr_acc;
  logic [AWIDTH-1:0] top_idx;
  logic [AWIDTH-1:0] rd_addr;
  logic [AWIDTH-1:0] wr_addr;

  assign is_empty = (usedw == '0);
  assign is_full  = (usedw == DEPTH_W);

  // LIFO keeps the stack at mem[0 .. usedw-1]; FIFO uses the circular pointers.
  // Mode only changes while empty, so the pointers stay equal across LIFO periods.
  always_comb begin
    rd_acc  = bus.rdreq_i && !is_empty;
    wr_acc  = bus.wrreq_i && (!is_full || rd_acc);
    top_idx = usedw[AWIDTH-1:0] - ONE_A;
    if (mode) begin
      rd_addr = rd_ptr;
      wr_addr = wr_ptr;
    end else begin
      rd_addr = top_idx;
      wr_addr = rd_acc ? top_idx : usedw[AWIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_addr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      usedw  <= '0;
      q      <= '0;
      mode   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // Nonblocking read sees the pre-write word on a simultaneous LIFO replace.
      if (rd_acc) begin
        q <= mem[rd_addr];
      end
      if (mode) begin
        if (rd_acc) begin
          rd_ptr <= rd_ptr + ONE_A;
        end
        if (wr_acc) begin
          wr_ptr <= wr_ptr + ONE_A;
        end
      end
      case ({wr_acc, rd_acc})
        2'b10:   usedw <= usedw + ONE_W;
        2'b01:   usedw <= usedw - ONE_W;
        default: usedw <= usedw;
      endcase
      if (is_empty && !wr_acc) begin
        mode <= bus.mode_i;
      end
    end
  end

`ifdef LIFO_FIFO_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.clr_err_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.wrreq_i && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (bus.rdreq_i && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.overflow_o  = overflow;
  assign bus.underflow_o = underflow;
`endif

  assign bus.q_o            = q;
  assign bus.mode_o         = mode;
  assign bus.usedw_o        = usedw;
  assign bus.empty_o        = is_empty;
  assign bus.full_o         = is_full;
  assign bus.almost_empty_o = (usedw <= AE_W);
  assign bus.almost_full_o  = (usedw >= AF_W);
endmodule

// File: tb/tb_lifo_fifo.sv
// Randomized and directed bench for lifo_fifo against a queue-based reference model.
module tb_lifo_fifo;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lifo_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) ifc ();

  lifo_fifo #(
    .DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
  ) dut (
    .clk_i (clk),
    .srst_i(rst),
    .bus   (ifc)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q   = '0;
  logic          m_mode = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  initial begin
    ifc.mode_i  = 1'b0;
    ifc.wrreq_i = 1'b0;
    ifc.rdreq_i = 1'b0;
    ifc.data_i  = '0;
`ifdef LIFO_FIFO_ERR_FLAGS_EN
    ifc.clr_err_i = 1'b0;
`endif
  end

  task automatic model_reset();
    mq.delete();
    m_q    = '0;
    m_mode = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock of stimulus; returns #1 after the edge with the model updated.
  task automatic drive(input logic wr, input logic rd, input logic [DW-1:0] d,
                       input logic m, input logic clr);
    int   n;
    logic rd_a;
    logic wr_a;
    ifc.wrreq_i = wr;
    ifc.rdreq_i = rd;
    ifc.data_i  = d;
    ifc.mode_i  = m;
`ifdef LIFO_FIFO_ERR_FLAGS_EN
    ifc.clr_err_i = clr;
`endif
    n    = mq.size();
    rd_a = rd && (n != 0);
    wr_a = wr && ((n != DEPTH) || rd_a);
    @(posedge clk);
    if (rd_a) m_q = m_mode ? mq.pop_front() : mq.pop_back();
    if (wr_a) mq.push_back(d);
    if (n == 0 && !wr_a) m_mode = m;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wr && !wr_a) m_ovf = 1'b1;
      if (rd && !rd_a) m_unf = 1'b1;
    end
    #1;
    ifc.wrreq_i = 1'b0;
    ifc.rdreq_i = 1'b0;
`ifdef LIFO_FIFO_ERR_FLAGS_EN
    ifc.clr_err_i = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifc.usedw_o !== 4'd0 || ifc.empty_o !== 1'b1 || ifc.almost_empty_o !== 1'b1 ||
        ifc.full_o !== 1'b0 || ifc.almost_full_o !== 1'b0 || ifc.q_o !== 16'h0 ||
        ifc.mode_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: usedw=%0d empty=%b ae=%b full=%b af=%b q=%h mode=%b, want 0 1 1 0 0 0000 0",
               ifc.usedw_o, ifc.empty_o, ifc.almost_empty_o, ifc.full_o, ifc.almost_full_o,
               ifc.q_o, ifc.mode_o);
    end
`ifdef LIFO_FIFO_ERR_FLAGS_EN
    checks++;
    if (ifc.overflow_o !== 1'b0 || ifc.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: ovf=%b unf=%b want 0 0", ifc.overflow_o, ifc.underflow_o);
    end
`endif
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_lifo_full();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
      checks++;
      if (ifc.usedw_o !== 4'(i > 8 ? 8 : i) || ifc.full_o !== (i >= 8) ||
          ifc.almost_full_o !== (i >= AF)) begin
        errors++;
        $display("FAIL lifo_fill[%0d]: usedw=%0d full=%b af=%b", i, ifc.usedw_o, ifc.full_o,
                 ifc.almost_full_o);
      end
    end
`ifdef LIFO_FIFO_ERR_FLAGS_EN
    checks++;
    if (ifc.overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b want 1", ifc.overflow_o);
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (ifc.q_o !== 16'(8 - i) || ifc.usedw_o !== 4'(7 - i)) begin
        errors++;
        $display("FAIL lifo_read[%0d]: q=%h usedw=%0d want %h %0d", i, ifc.q_o, ifc.usedw_o,
                 16'(8 - i), 7 - i);
      end
    end
    checks++;
    if (ifc.empty_o !== 1'b1) begin
      errors++;
      $display("FAIL lifo_drained: empty=%b want 1", ifc.empty_o);
    end
  endtask

  task automatic test_fifo();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (ifc.mode_o !== 1'b1) begin
      errors++;
      $display("FAIL fifo_mode: mode=%b want 1", ifc.mode_o);
    end
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, '0, 1'b1, 1'b0);
      checks++;
      if (ifc.q_o !== 16'(i)) begin
        errors++;
        $display("FAIL fifo_read[%0d]: q=%h want %h", i, ifc.q_o, 16'(i));
      end
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i >= 3) && (i % 4 != 0), 16'(16'h100 + i), 1'b1, 1'b0);
      checks++;
      if (ifc.q_o !== m_q || ifc.usedw_o !== 4'(mq.size())) begin
        errors++;
        $display("FAIL fifo_wrap[%0d]: q=%h usedw=%0d want %h %0d", i, ifc.q_o, ifc.usedw_o,
                 m_q, mq.size());
      end
    end
    while (mq.size() != 0) begin
      drive(1'b0, 1'b1, '0, 1'b1, 1'b0);
      checks++;
      if (ifc.q_o !== m_q || ifc.usedw_o !== 4'(mq.size())) begin
        errors++;
        $display("FAIL fifo_drain: q=%h usedw=%0d want %h %0d", ifc.q_o, ifc.usedw_o, m_q,
                 mq.size());
      end
    end
  endtask

  task automatic test_simul();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'hBBBB, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'hCCCC, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'hDDDD, 1'b0, 1'b0);
    checks++;
    if (ifc.q_o !== 16'hCCCC || ifc.usedw_o !== 4'd3 || ifc.mode_o !== 1'b0) begin
      errors++;
      $display("FAIL lifo_rdwr: q=%h usedw=%0d mode=%b want cccc 3 0", ifc.q_o, ifc.usedw_o,
               ifc.mode_o);
    end
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    checks++;
    if (ifc.q_o !== 16'hDDDD) begin
      errors++;
      $display("FAIL lifo_replaced: q=%h want dddd", ifc.q_o);
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 16'(16'h200 + i), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'hEEEE, 1'b0, 1'b0);
    checks++;
    if (ifc.q_o !== 16'h0205 || ifc.full_o !== 1'b1 || ifc.usedw_o !== 4'd8) begin
      errors++;
      $display("FAIL full_rdwr: q=%h full=%b usedw=%0d want 0205 1 8", ifc.q_o, ifc.full_o,
               ifc.usedw_o);
    end
    while (mq.size() != 0) begin
      drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (ifc.q_o !== m_q) begin
        errors++;
        $display("FAIL full_drain: q=%h want %h", ifc.q_o, m_q);
      end
    end
  endtask

  task automatic test_empty();
    logic [DW-1:0] held;
    held = m_q;
    drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    checks++;
    if (ifc.q_o !== held || ifc.usedw_o !== 4'd1) begin
      errors++;
      $display("FAIL empty_rdwr: q=%h usedw=%0d want %h 1", ifc.q_o, ifc.usedw_o, held);
    end
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    checks++;
    if (ifc.q_o !== 16'h1234 || ifc.usedw_o !== 4'd0 || ifc.empty_o !== 1'b1) begin
      errors++;
      $display("FAIL empty_reads: q=%h usedw=%0d empty=%b want 1234 0 1", ifc.q_o,
               ifc.usedw_o, ifc.empty_o);
    end
`ifdef LIFO_FIFO_ERR_FLAGS_EN
    checks++;
    if (ifc.underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set: got %b want 1", ifc.underflow_o);
    end
    drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
    checks++;
    if (ifc.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clr: got %b want 0", ifc.underflow_o);
    end
`endif
  endtask

  task automatic test_mode_toggle();
    drive(1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0022, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b1, 1'b0);
    checks++;
    if (ifc.mode_o !== 1'b0 || ifc.q_o !== 16'h0022) begin
      errors++;
      $display("FAIL mode_hold: mode=%b q=%h want 0 0022", ifc.mode_o, ifc.q_o);
    end
    drive(1'b0, 1'b1, '0, 1'b1, 1'b0);
    checks++;
    if (ifc.mode_o !== 1'b0 || ifc.q_o !== 16'h0011) begin
      errors++;
      $display("FAIL mode_drain: mode=%b q=%h want 0 0011", ifc.mode_o, ifc.q_o);
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (ifc.mode_o !== 1'b1) begin
      errors++;
      $display("FAIL mode_load: mode=%b want 1", ifc.mode_o);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 16'(16'h300 + i), 1'b1, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.usedw_o !== 4'd0 || ifc.empty_o !== 1'b1 || ifc.mode_o !== 1'b0 ||
        ifc.q_o !== 16'h0 || ifc.full_o !== 1'b0 || ifc.almost_full_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: usedw=%0d empty=%b mode=%b q=%h want 0 1 0 0000",
               ifc.usedw_o, ifc.empty_o, ifc.mode_o, ifc.q_o);
    end
    #1;
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 16'h0A0A, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0B0B, 1'b0, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    checks++;
    if (ifc.q_o !== 16'h0B0B || ifc.usedw_o !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_lifo: q=%h usedw=%0d want 0b0b 1", ifc.q_o, ifc.usedw_o);
    end
  endtask

  task automatic test_random();
    logic m;
    int   pw;
    m = m_mode;
    for (int i = 0; i < 600; i++) begin
      pw = ((i / 40) % 2 == 0) ? 75 : 25;
      if ($urandom_range(0, 9) == 0) m = ~m;
      drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
            16'($urandom), m, $urandom_range(0, 29) == 0);
      checks++;
      if (ifc.q_o !== m_q || ifc.usedw_o !== 4'(mq.size()) || ifc.mode_o !== m_mode ||
          ifc.empty_o !== (mq.size() == 0) || ifc.full_o !== (mq.size() == DEPTH) ||
          ifc.almost_empty_o !== (mq.size() <= AE) || ifc.almost_full_o !== (mq.size() >= AF)) begin
        errors++;
        $display("FAIL random[%0d]: q=%h usedw=%0d mode=%b e=%b f=%b ae=%b af=%b want q=%h usedw=%0d mode=%b",
                 i, ifc.q_o, ifc.usedw_o, ifc.mode_o, ifc.empty_o, ifc.full_o,
                 ifc.almost_empty_o, ifc.almost_full_o, m_q, mq.size(), m_mode);
      end
`ifdef LIFO_FIFO_ERR_FLAGS_EN
      checks++;
      if (ifc.overflow_o !== m_ovf || ifc.underflow_o !== m_unf) begin
        errors++;
        $display("FAIL random_err[%0d]: ovf=%b unf=%b want %b %b", i, ifc.overflow_o,
                 ifc.underflow_o, m_ovf, m_unf);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_lifo_full();
    test_fifo();
    test_simul();
    test_empty();
    test_mode_toggle();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
